// File: rtl/xgriscv_mem_stage.sv
// rtl/xgriscv_mem_stage.sv - memory-access stage: aligned B/H/W loads and stores over a req/gnt/rvalid port
module xgriscv_mem_stage #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_aluout,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic            ex_memread,
    input  logic            ex_memwrite,
    input  logic [2:0]      ex_funct3,
    input  logic [4:0]      ex_rd,
    input  logic            ex_regwrite,
    output logic            dm_req,
    output logic            dm_we,
    output logic [AW-1:0]   dm_addr,
    output logic [XLEN-1:0] dm_wdata,
    output logic [3:0]      dm_wstrb,
    input  logic            dm_gnt,
    input  logic            dm_rvalid,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_regwrite,
    output logic            wb_misalign
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t          state;
    state_t          state_nxt;

    logic [XLEN-1:0] lat_aluout;
    logic [2:0]      lat_funct3;
    logic [4:0]      lat_rd;
    logic            lat_regwrite;
    logic            lat_store;

    logic            accept;
    logic            is_mem;
    logic            is_store;
    logic            size_byte;
    logic            size_half;
    logic            misalign;
    logic [3:0]      wstrb_nxt;
    logic [XLEN-1:0] wdata_nxt;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;

    assign ex_ready  = (state == S_IDLE);
    assign accept    = ex_valid && ex_ready;
    assign is_mem    = ex_memread || ex_memwrite;
    assign is_store  = ex_memwrite && !ex_memread;
    // funct3[1:0] picks size; every encoding other than 00/01 behaves as a word
    assign size_byte = (ex_funct3[1:0] == 2'b00);
    assign size_half = (ex_funct3[1:0] == 2'b01);
    assign misalign  = is_mem && ((size_half && ex_aluout[0]) ||
                                  (!size_half && !size_byte && (ex_aluout[1:0] != 2'b00)));

    always_comb begin
        wstrb_nxt = 4'b0000;
        wdata_nxt = ex_wdata;
        if (size_byte) begin
            wdata_nxt = {4{ex_wdata[7:0]}};
            wstrb_nxt = 4'b0001 << ex_aluout[1:0];
        end else if (size_half) begin
            wdata_nxt = {2{ex_wdata[15:0]}};
            wstrb_nxt = 4'b0011 << ex_aluout[1:0];
        end else begin
            wstrb_nxt = 4'b1111;
        end
        if (!is_store) begin
            wstrb_nxt = 4'b0000;
        end
    end

    assign byte_sel = dm_rdata[{lat_aluout[1:0], 3'b000} +: 8];
    assign half_sel = dm_rdata[{lat_aluout[1], 4'b0000} +: 16];

    always_comb begin
        load_data = dm_rdata;
        if (lat_funct3[1:0] == 2'b00) begin
            load_data = {{(XLEN-8){byte_sel[7] && !lat_funct3[2]}}, byte_sel};
        end else if (lat_funct3[1:0] == 2'b01) begin
            load_data = {{(XLEN-16){half_sel[15] && !lat_funct3[2]}}, half_sel};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && is_mem && !misalign) state_nxt = S_REQ;
            S_REQ:  if (dm_gnt) state_nxt = lat_store ? S_IDLE : S_WAIT;
            S_WAIT: if (dm_rvalid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= '0;
            dm_wdata     <= '0;
            dm_wstrb     <= 4'b0000;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= 5'd0;
            wb_regwrite  <= 1'b0;
            wb_misalign  <= 1'b0;
            lat_aluout   <= '0;
            lat_funct3   <= 3'b000;
            lat_rd       <= 5'd0;
            lat_regwrite <= 1'b0;
            lat_store    <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_misalign <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_aluout   <= ex_aluout;
                        lat_funct3   <= ex_funct3;
                        lat_rd       <= ex_rd;
                        lat_regwrite <= ex_regwrite;
                        lat_store    <= is_store;
                        if (is_mem && !misalign) begin
                            dm_req   <= 1'b1;
                            dm_we    <= is_store;
                            dm_addr  <= {ex_aluout[AW-1:2], 2'b00};
                            dm_wdata <= wdata_nxt;
                            dm_wstrb <= wstrb_nxt;
                        end else begin
                            wb_valid    <= 1'b1;
                            wb_data     <= ex_aluout;
                            wb_rd       <= ex_rd;
                            wb_regwrite <= ex_regwrite && !misalign;
                            wb_misalign <= misalign;
                        end
                    end
                end
                S_REQ: begin
                    if (dm_gnt) begin
                        dm_req <= 1'b0;
                        dm_we  <= 1'b0;
                        if (lat_store) begin
                            wb_valid <= 1'b1;
                            wb_data  <= lat_aluout;
                            wb_rd    <= lat_rd;
                        end
                    end
                end
                S_WAIT: begin
                    if (dm_rvalid) begin
                        wb_valid    <= 1'b1;
                        wb_data     <= load_data;
                        wb_rd       <= lat_rd;
                        wb_regwrite <= lat_regwrite;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xgriscv_mem_stage.sv
// tb/tb_xgriscv_mem_stage.sv - randomized self-checking bench for xgriscv_mem_stage
module tb_xgriscv_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_aluout = '0;
    logic [31:0] ex_wdata = '0;
    logic        ex_memread = 1'b0;
    logic        ex_memwrite = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_regwrite = 1'b0;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_gnt = 1'b0;
    logic        dm_rvalid = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        wb_misalign;

    int total = 0;
    int bad = 0;
    logic [31:0] last_wb;
    logic [31:0] last_wstrb;
    logic [31:0] last_wdata;
    bit          saw_req;

    xgriscv_mem_stage #(.XLEN(32), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_aluout(ex_aluout), .ex_wdata(ex_wdata),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_funct3(ex_funct3),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        int unsigned a;
        a = addr % 4;
        if (f3[1:0] == 2'b00) begin
            v = (rdata >> (8 * a)) & 32'hFF;
            if (!f3[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (f3[1:0] == 2'b01) begin
            v = (rdata >> (16 * (a / 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // One instruction from accept to writeback; gd/rvd are the extra gnt/rvalid wait cycles
    task automatic do_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic rw, input int gd, input int rvd, input logic [31:0] rdata,
                         input bit junk);
        bit mem, load, mis;
        int unsigned a;
        logic [31:0] e_strb, e_wdata, e_addr;
        mem  = rd_op || wr_op;
        load = rd_op;
        a    = addr % 4;
        mis  = mem && ((f3[1:0] == 2'b01 && a % 2 != 0) || (f3[1:0] != 2'b00 && f3[1:0] != 2'b01 && a != 0));
        e_addr = addr - a;
        if (f3[1:0] == 2'b00) begin
            e_strb = 32'd1 << a;  e_wdata = (wdata & 32'hFF) * 32'h0101_0101;
        end else if (f3[1:0] == 2'b01) begin
            e_strb = 32'd3 << a;  e_wdata = (wdata & 32'hFFFF) * 32'h0001_0001;
        end else begin
            e_strb = 32'hF;       e_wdata = wdata;
        end
        if (load) e_strb = 0;

        ex_valid = 1'b1; ex_memread = rd_op; ex_memwrite = wr_op; ex_funct3 = f3;
        ex_aluout = addr; ex_wdata = wdata; ex_rd = rd; ex_regwrite = rw;
        check("ready_at_issue", {31'd0, ex_ready}, 32'd1);
        step();
        ex_valid = 1'b0;
        saw_req = dm_req;

        if (!mem || mis) begin
            check("direct_wb_valid", {31'd0, wb_valid}, 32'd1);
            check("direct_wb_data", wb_data, addr);
            check("direct_wb_rd", {27'd0, wb_rd}, {27'd0, rd});
            check("direct_wb_regwrite", {31'd0, wb_regwrite}, {31'd0, rw && !mis});
            check("direct_wb_misalign", {31'd0, wb_misalign}, {31'd0, mis});
            check("direct_no_req", {31'd0, dm_req}, 32'd0);
            last_wb = wb_data;
            return;
        end

        for (int k = 0; k <= gd; k++) begin
            check("req_held", {31'd0, dm_req}, 32'd1);
            check("req_we", {31'd0, dm_we}, {31'd0, !load});
            check("req_addr", dm_addr, e_addr);
            check("req_wstrb", {28'd0, dm_wstrb}, e_strb);
            if (!load) check("req_wdata", dm_wdata, e_wdata);
            check("req_not_ready", {31'd0, ex_ready}, 32'd0);
            check("req_no_wb", {31'd0, wb_valid}, 32'd0);
            last_wstrb = {28'd0, dm_wstrb};
            last_wdata = dm_wdata;
            dm_gnt    = (k == gd);
            dm_rvalid = junk && ($urandom % 2 == 1);
            dm_rdata  = $urandom;
            step();
        end
        dm_gnt = 1'b0;
        dm_rvalid = 1'b0;
        check("req_dropped", {31'd0, dm_req}, 32'd0);

        if (!load) begin
            check("store_wb_valid", {31'd0, wb_valid}, 32'd1);
            check("store_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
            check("store_ready", {31'd0, ex_ready}, 32'd1);
            return;
        end

        for (int k = 0; k <= rvd; k++) begin
            check("wait_no_wb", {31'd0, wb_valid}, 32'd0);
            check("wait_not_ready", {31'd0, ex_ready}, 32'd0);
            dm_rvalid = (k == rvd);
            dm_rdata  = (k == rvd) ? rdata : $urandom;
            step();
        end
        dm_rvalid = 1'b0;
        check("load_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("load_wb_data", wb_data, exp_load(f3, addr, rdata));
        check("load_wb_rd", {27'd0, wb_rd}, {27'd0, rd});
        check("load_wb_regwrite", {31'd0, wb_regwrite}, {31'd0, rw});
        check("load_wb_misalign", {31'd0, wb_misalign}, 32'd0);
        check("load_ready", {31'd0, ex_ready}, 32'd1);
        last_wb = wb_data;
    endtask

    initial begin
        logic [2:0] f3;
        logic rd_op, wr_op;

        repeat (2) step();
        check("rst_dm_req", {31'd0, dm_req}, 32'd0);
        check("rst_dm_we", {31'd0, dm_we}, 32'd0);
        check("rst_dm_addr", dm_addr, 32'd0);
        check("rst_dm_wdata", dm_wdata, 32'd0);
        check("rst_dm_wstrb", {28'd0, dm_wstrb}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
        check("rst_wb_misalign", {31'd0, wb_misalign}, 32'd0);
        check("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        reset = 1'b0;
        step();

        // three ALU ops back to back, one per cycle
        ex_valid = 1'b1; ex_regwrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_aluout = 32'd5 + i;
            ex_rd = 5'(i + 1);
            check("b2b_ready", {31'd0, ex_ready}, 32'd1);
            step();
            check("b2b_wb_valid", {31'd0, wb_valid}, 32'd1);
            check("b2b_wb_data", wb_data, 32'd5 + i);
            check("b2b_wb_rd", {27'd0, wb_rd}, i + 1);
        end
        ex_valid = 1'b0;
        step();
        check("b2b_idle_wb", {31'd0, wb_valid}, 32'd0);

        do_op(1, 0, 3'b000, 32'h103, 0, 5'd4, 1, 0, 1, 32'h80FF_1234, 0);
        check("lb_value", last_wb, 32'hFFFF_FF80);
        do_op(1, 0, 3'b100, 32'h103, 0, 5'd4, 1, 0, 1, 32'h80FF_1234, 0);
        check("lbu_value", last_wb, 32'h0000_0080);
        do_op(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd0, 0, 3, 0, 0, 0);
        check("sh_wstrb", last_wstrb, 32'hC);
        check("sh_wdata", last_wdata, 32'hABCD_ABCD);
        do_op(1, 0, 3'b010, 32'h301, 0, 5'd7, 1, 0, 0, 0, 0);
        check("lw_mis_no_req", {31'd0, saw_req}, 32'd0);
        step();
        check("lw_mis_no_req_later", {31'd0, dm_req}, 32'd0);
        do_op(1, 0, 3'b001, 32'h402, 0, 5'd8, 1, 2, 0, 32'h8001_0000, 1);
        check("lh_value", last_wb, 32'hFFFF_8001);
        do_op(1, 0, 3'b101, 32'h402, 0, 5'd8, 1, 2, 0, 32'h8001_0000, 1);
        check("lhu_value", last_wb, 32'h0000_8001);

        // reset while waiting for load data, then a stale rvalid
        ex_valid = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0; ex_funct3 = 3'b010;
        ex_aluout = 32'h500; ex_rd = 5'd9; ex_regwrite = 1'b1;
        step();
        ex_valid = 1'b0;
        dm_gnt = 1'b1;
        step();
        dm_gnt = 1'b0;
        check("rstw_in_wait", {31'd0, ex_ready}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstw_ready", {31'd0, ex_ready}, 32'd1);
        check("rstw_req", {31'd0, dm_req}, 32'd0);
        dm_rvalid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
        step();
        dm_rvalid = 1'b0;
        check("rstw_no_wb", {31'd0, wb_valid}, 32'd0);
        check("rstw_ready2", {31'd0, ex_ready}, 32'd1);
        step();
        check("rstw_no_wb2", {31'd0, wb_valid}, 32'd0);

        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            rd_op = (kind >= 2 && kind <= 6) || kind == 9;
            wr_op = (kind >= 7);
            f3 = 3'($urandom);
            if (wr_op && !rd_op && (f3 == 3'b100 || f3 == 3'b101)) f3 = 3'b000;
            do_op(rd_op, wr_op, f3, 32'h1000 + ($urandom % 256), $urandom, 5'($urandom),
                  1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                  1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
